// File: rtl/circuito_exp3_desafio_pkg.sv
// rtl/circuito_exp3_desafio_pkg.sv - state codes and ROM sequence for the sequence-checking game
package circuito_exp3_desafio_pkg;

    localparam int DATA_W = 4;

    // Encodings double as the digit shown on db_estado.
    typedef enum logic [3:0] {
        ST_INICIAL    = 4'h0,
        ST_PREPARACAO = 4'h1,
        ST_REGISTRA   = 4'h2,
        ST_COMPARACAO = 4'h3,
        ST_PROXIMO    = 4'h4,
        ST_FIM_ACERTO = 4'hA,
        ST_FIM_ERRO   = 4'hE
    } estado_t;

    function automatic logic [DATA_W-1:0] rom_read(input logic [3:0] addr);
        logic [DATA_W-1:0] data;
        case (addr)
            4'd0:    data = 4'h1;
            4'd1:    data = 4'h2;
            4'd2:    data = 4'h4;
            4'd3:    data = 4'h8;
            4'd4:    data = 4'h4;
            4'd5:    data = 4'h2;
            4'd6:    data = 4'h1;
            4'd7:    data = 4'h1;
            4'd8:    data = 4'h2;
            4'd9:    data = 4'h2;
            4'd10:   data = 4'h4;
            4'd11:   data = 4'h4;
            4'd12:   data = 4'h8;
            4'd13:   data = 4'h8;
            4'd14:   data = 4'h1;
            default: data = 4'h4;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/circuito_exp3_desafio_hexa7seg.sv
// rtl/circuito_exp3_desafio_hexa7seg.sv - hex digit to active-low 7-segment (g..a) decoder
module circuito_exp3_desafio_hexa7seg (
    input  logic [3:0] hexa_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (hexa_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/circuito_exp3_desafio.sv
// rtl/circuito_exp3_desafio.sv - sequence-checking game: FSM, counter, jogada register, ROM compare
module circuito_exp3_desafio
    import circuito_exp3_desafio_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);

    estado_t     state_q, state_d;
    logic [3:0]  contagem_q;
    logic [3:0]  jogada_q;
    logic        pronto_q, acertou_q, errou_q;
    logic [3:0]  memoria;
    logic        igual, fim;

    assign memoria = rom_read(contagem_q);
    assign igual   = (jogada_q == memoria);
    assign fim     = (contagem_q == 4'd15);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INICIAL:    if (iniciar) state_d = ST_PREPARACAO;
            ST_PREPARACAO: state_d = ST_REGISTRA;
            ST_REGISTRA:   state_d = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!igual)   state_d = ST_FIM_ERRO;
                else if (fim) state_d = ST_FIM_ACERTO;
                else          state_d = ST_PROXIMO;
            end
            ST_PROXIMO:    state_d = ST_REGISTRA;
            ST_FIM_ACERTO,
            ST_FIM_ERRO:   if (iniciar) state_d = ST_PREPARACAO;
            default:       state_d = ST_INICIAL;
        endcase
    end

    // Outputs and datapath are driven from state_d so that they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INICIAL;
            contagem_q <= 4'd0;
            jogada_q   <= 4'd0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pronto_q  <= (state_d == ST_FIM_ACERTO) || (state_d == ST_FIM_ERRO);
            acertou_q <= (state_d == ST_FIM_ACERTO);
            errou_q   <= (state_d == ST_FIM_ERRO);
            if (state_d == ST_PREPARACAO || state_q == ST_PREPARACAO) begin
                contagem_q <= 4'd0;
                jogada_q   <= 4'd0;
            end else begin
                if (state_q == ST_REGISTRA) jogada_q   <= chaves;
                if (state_q == ST_PROXIMO)  contagem_q <= contagem_q + 4'd1;
            end
        end
    end

    assign pronto     = pronto_q;
    assign acertou    = acertou_q;
    assign errou      = errou_q;
    assign db_igual   = igual;
    assign db_iniciar = iniciar;

    circuito_exp3_desafio_hexa7seg u_seg_contagem (.hexa_i(contagem_q), .seg_o(db_contagem));
    circuito_exp3_desafio_hexa7seg u_seg_memoria  (.hexa_i(memoria),    .seg_o(db_memoria));
    circuito_exp3_desafio_hexa7seg u_seg_chaves   (.hexa_i(jogada_q),   .seg_o(db_chaves));
    circuito_exp3_desafio_hexa7seg u_seg_estado   (.hexa_i(state_q),    .seg_o(db_estado));

endmodule

// File: tb/tb_circuito_exp3_desafio.sv
// tb/tb_circuito_exp3_desafio.sv - scoreboard bench for circuito_exp3_desafio
module tb_circuito_exp3_desafio;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'd0;
    logic       pronto, acertou, errou, db_igual, db_iniciar;
    logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

    circuito_exp3_desafio dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .pronto(pronto), .acertou(acertou), .errou(errou), .db_igual(db_igual),
        .db_iniciar(db_iniciar), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_chaves(db_chaves), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        string      tag;
        logic [3:0] st;
        logic [3:0] cnt;
        logic [3:0] jog;
        logic       pr, ac, er;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [3:0] rom_tb [16];
    logic [6:0] seg_tb [16];
    logic [3:0] good_seq [16];
    logic [3:0] err_seq [16];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input string fld, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", tag, fld, act, req);
        end
    endtask

    task automatic compare(input exp_t e);
        logic [3:0] mem;
        mem = rom_tb[e.cnt];
        chk(e.tag, "estado",   db_estado,   seg_tb[e.st]);
        chk(e.tag, "contagem", db_contagem, seg_tb[e.cnt]);
        chk(e.tag, "memoria",  db_memoria,  seg_tb[mem]);
        chk(e.tag, "chaves",   db_chaves,   seg_tb[e.jog]);
        chk(e.tag, "igual",    {6'd0, db_igual}, {6'd0, (e.jog == mem)});
        chk(e.tag, "pronto",   {6'd0, pronto},   {6'd0, e.pr});
        chk(e.tag, "acertou",  {6'd0, acertou},  {6'd0, e.ac});
        chk(e.tag, "errou",    {6'd0, errou},    {6'd0, e.er});
    endtask

    // Monitor: also wakes on a reset rise so the asynchronous abort is observed before any clock edge.
    always @(negedge clock or posedge reset) begin
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s.stale got=%0d want=%0d", e.tag, cyc, e.due);
            end else begin
                compare(e);
            end
        end
    end

    task automatic push(input int due, input string tag, input logic [3:0] st, input logic [3:0] cnt,
                        input logic [3:0] jog, input logic pr, input logic ac, input logic er);
        exp_t e;
        e.due = due; e.tag = tag; e.st = st; e.cnt = cnt; e.jog = jog;
        e.pr = pr; e.ac = ac; e.er = er;
        sb.push_back(e);
    endtask

    // Drive at a falling edge and predict the state after the following rising edge.
    task automatic step(input logic ini, input logic [3:0] ch, input string tag, input logic [3:0] st,
                        input logic [3:0] cnt, input logic [3:0] jog, input logic pr, input logic ac,
                        input logic er);
        @(negedge clock);
        iniciar = ini;
        chaves  = ch;
        push(cyc + 1, tag, st, cnt, jog, pr, ac, er);
    endtask

    task automatic play(input logic [3:0] vals [16], input int stop_idx, input string tag);
        step(1'b1, 4'd0, {tag, "_prep"}, 4'h1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, {tag, "_reg0"}, 4'h2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] prev;
            prev = (i == 0) ? 4'd0 : vals[i-1];
            step(1'b0, vals[i], $sformatf("%s_cmp%0d", tag, i), 4'h3, 4'(i), vals[i], 1'b0, 1'b0, 1'b0);
            if (i == stop_idx) return;
            if (vals[i] != rom_tb[i]) begin
                step(1'b0, vals[i], $sformatf("%s_erro%0d", tag, i), 4'hE, 4'(i), vals[i], 1'b1, 1'b0, 1'b1);
                return;
            end
            if (i == 15) begin
                step(1'b0, vals[i], {tag, "_acerto"}, 4'hA, 4'd15, vals[i], 1'b1, 1'b1, 1'b0);
                return;
            end
            step(1'b0, vals[i], $sformatf("%s_prox%0d", tag, i), 4'h4, 4'(i), vals[i], 1'b0, 1'b0, 1'b0);
            step(1'b0, vals[i], $sformatf("%s_reg%0d", tag, i + 1), 4'h2, 4'(i + 1), vals[i], 1'b0, 1'b0, 1'b0);
            if (prev == 4'hF) $display("unreachable");
        end
    endtask

    initial begin
        rom_tb   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                     4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
        seg_tb   = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                     7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                     7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        good_seq = rom_tb;
        err_seq  = rom_tb;
        err_seq[4] = 4'h1;

        repeat (2) @(negedge clock);
        push(cyc + 1, "reset", 4'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 5; k++)
            step(1'b0, 4'(k + 3), $sformatf("idle%0d", k), 4'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        play(good_seq, -1, "g1");
        step(1'b0, 4'h7, "acerto_hold", 4'hA, 4'd15, 4'h4, 1'b1, 1'b1, 1'b0);

        play(err_seq, -1, "e1");
        step(1'b0, 4'h2, "erro_hold0", 4'hE, 4'd4, 4'h1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'h4, "erro_hold1", 4'hE, 4'd4, 4'h1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'hF, "erro_hold2", 4'hE, 4'd4, 4'h1, 1'b1, 1'b0, 1'b1);

        play(good_seq, -1, "g2");

        play(good_seq, 6, "r1");
        @(negedge clock);
        #3;
        push(cyc, "abort_now", 4'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        push(cyc + 1, "abort_hold", 4'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 4'h1, "post_reset", 4'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clock);
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
